// File: rtl/register_file.sv
// Architectural register file: two combinational read ports with EX > MEM > WB forwarding, one WB write port.
// Latency: reads zero-cycle, writes commit on the rising edge; no backpressure, every request is served the same cycle.
module register_file #(
  parameter int REG_COUNT  = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wb_write_enable,
  input  logic [ADDR_WIDTH-1:0] wb_write_addr,
  input  logic [DATA_WIDTH-1:0] wb_write_data,
  input  logic                  ex_write_enable,
  input  logic [ADDR_WIDTH-1:0] ex_write_addr,
  input  logic [DATA_WIDTH-1:0] ex_write_data,
  input  logic                  mem_write_enable,
  input  logic [ADDR_WIDTH-1:0] mem_write_addr,
  input  logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic                  read1_enable,
  input  logic [ADDR_WIDTH-1:0] read1_addr,
  output logic [DATA_WIDTH-1:0] read1_data,
  input  logic                  read2_enable,
  input  logic [ADDR_WIDTH-1:0] read2_addr,
  output logic [DATA_WIDTH-1:0] read2_data
);

  logic [REG_COUNT-1:0][DATA_WIDTH-1:0] regs_q;
  logic [REG_COUNT-1:0][DATA_WIDTH-1:0] regs_d;

  always_comb begin
    regs_d = regs_q;
    if (wb_write_enable && (wb_write_addr != '0) && (int'(wb_write_addr) < REG_COUNT)) begin
      regs_d[wb_write_addr] = wb_write_data;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // r0 and out-of-range addresses never see forwarded values.
  function automatic logic [DATA_WIDTH-1:0] read_port(
    input logic                  en,
    input logic [ADDR_WIDTH-1:0] addr
  );
    logic [DATA_WIDTH-1:0] res;
    res = '0;
    if (reset || !en || (addr == '0) || (int'(addr) >= REG_COUNT)) begin
      res = '0;
    end else if (ex_write_enable && (ex_write_addr == addr)) begin
      res = ex_write_data;
    end else if (mem_write_enable && (mem_write_addr == addr)) begin
      res = mem_write_data;
    end else if (wb_write_enable && (wb_write_addr == addr)) begin
      res = wb_write_data;
    end else begin
      res = regs_q[addr];
    end
    return res;
  endfunction

  assign read1_data = read_port(read1_enable, read1_addr);
  assign read2_data = read_port(read2_enable, read2_addr);

endmodule

// File: tb/tb_register_file.sv
// Randomized and directed bench for register_file against an array-based reference model.
module tb_register_file;
  localparam int RC = 32;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          wb_write_enable, ex_write_enable, mem_write_enable;
  logic [AW-1:0] wb_write_addr, ex_write_addr, mem_write_addr;
  logic [DW-1:0] wb_write_data, ex_write_data, mem_write_data;
  logic          read1_enable, read2_enable;
  logic [AW-1:0] read1_addr, read2_addr;
  logic [DW-1:0] read1_data, read2_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] model [RC];

  register_file #(.REG_COUNT(RC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .wb_write_enable(wb_write_enable), .wb_write_addr(wb_write_addr), .wb_write_data(wb_write_data),
    .ex_write_enable(ex_write_enable), .ex_write_addr(ex_write_addr), .ex_write_data(ex_write_data),
    .mem_write_enable(mem_write_enable), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .read1_enable(read1_enable), .read1_addr(read1_addr), .read1_data(read1_data),
    .read2_enable(read2_enable), .read2_addr(read2_addr), .read2_data(read2_data)
  );

  always #5 clock = ~clock;

  // Architectural state: cleared by reset, committed only by the WB port.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      foreach (model[i]) model[i] = '0;
    end else if (wb_write_enable && wb_write_addr != 0) begin
      model[wb_write_addr] = wb_write_data;
    end
  end

  function automatic logic [DW-1:0] ref_read(input logic en, input logic [AW-1:0] a);
    if (reset || !en || a == 0) return '0;
    if (ex_write_enable && ex_write_addr == a) return ex_write_data;
    if (mem_write_enable && mem_write_addr == a) return mem_write_data;
    if (wb_write_enable && wb_write_addr == a) return wb_write_data;
    return model[a];
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wb_write_enable = 0; wb_write_addr = '0; wb_write_data = '0;
    ex_write_enable = 0; ex_write_addr = '0; ex_write_data = '0;
    mem_write_enable = 0; mem_write_addr = '0; mem_write_data = '0;
    read1_enable = 0; read1_addr = '0; read2_enable = 0; read2_addr = '0;
  endtask

  task automatic wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_write_enable = 1; wb_write_addr = a; wb_write_data = d;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    // Mostly a small pool so forwarding sources collide with read addresses.
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, RC - 1));
    return AW'($urandom_range(0, 3));
  endfunction

  initial begin
    idle();
    #1 reset = 1;
    #2;
    // Reset dominates everything, including live forward sources.
    for (int a = 1; a < RC; a++) begin
      read1_enable = 1; read2_enable = 1;
      read1_addr = AW'(a); read2_addr = AW'(a);
      ex_write_enable = 1; ex_write_addr = AW'(a); ex_write_data = 32'hCAFE0000 | a;
      #1;
      check("rst_r1", read1_data, '0);
      check("rst_r2", read2_data, '0);
    end
    idle();
    @(negedge clock); wb(5, 32'hDEADBEEF);
    @(negedge clock); reset = 0; idle(); read1_enable = 1; read1_addr = 5;
    #1 check("rst_write_lost", read1_data, '0);

    @(negedge clock); idle(); wb(7, 32'h12345678);
    @(negedge clock); idle(); read1_enable = 1; read1_addr = 7;
    #1 check("basic_rd", read1_data, 32'h12345678);
    read1_enable = 0;
    #1 check("basic_rd_dis", read1_data, '0);

    @(negedge clock); idle(); wb(0, 32'hFFFFFFFF);
    ex_write_enable = 1; ex_write_addr = 0; ex_write_data = 32'hAAAA0000;
    read1_enable = 1; read2_enable = 1;
    #1 check("r0_fwd_r1", read1_data, '0);
    check("r0_fwd_r2", read2_data, '0);
    @(negedge clock); idle(); read1_enable = 1; read2_enable = 1;
    #1 check("r0_after_r1", read1_data, '0);
    check("r0_after_r2", read2_data, '0);

    @(negedge clock); idle(); wb(3, 32'h1);
    @(negedge clock); wb(3, 32'h2); read2_enable = 1; read2_addr = 3;
    #1 check("bypass_same", read2_data, 32'h2);
    @(negedge clock); wb_write_enable = 0;
    #1 check("bypass_next", read2_data, 32'h2);

    @(negedge clock); idle(); wb(9, 32'h10);
    @(negedge clock);
    mem_write_enable = 1; mem_write_addr = 9; mem_write_data = 32'h20;
    ex_write_enable = 1; ex_write_addr = 9; ex_write_data = 32'h30;
    wb(9, 32'h40); read1_enable = 1; read1_addr = 9;
    #1 check("fwd_ex", read1_data, 32'h30);
    ex_write_enable = 0;
    #1 check("fwd_mem", read1_data, 32'h20);
    mem_write_enable = 0;
    #1 check("fwd_wb", read1_data, 32'h40);
    @(negedge clock); idle(); read1_enable = 1; read1_addr = 9;
    #1 check("fwd_commit", read1_data, 32'h40);

    @(negedge clock); idle(); wb(12, 32'h55);
    @(negedge clock); idle(); read1_enable = 1; read1_addr = 12;
    #1 check("async_pre", read1_data, 32'h55);
    #1 reset = 1;
    #1 check("async_during", read1_data, '0);
    #1 reset = 0;
    #1 check("async_after", read1_data, '0);

    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      reset = ($urandom_range(0, 49) == 0);
      wb_write_enable  = 1'($urandom_range(0, 1));
      wb_write_addr    = rnd_addr(); wb_write_data = $urandom;
      ex_write_enable  = ($urandom_range(0, 2) == 0);
      ex_write_addr    = rnd_addr(); ex_write_data = $urandom;
      mem_write_enable = ($urandom_range(0, 2) == 0);
      mem_write_addr   = rnd_addr(); mem_write_data = $urandom;
      read1_enable     = ($urandom_range(0, 7) != 0); read1_addr = rnd_addr();
      read2_enable     = ($urandom_range(0, 7) != 0);
      read2_addr       = ($urandom_range(0, 3) == 0) ? read1_addr : rnd_addr();
      #1;
      check("rand_r1", read1_data, ref_read(read1_enable, read1_addr));
      check("rand_r2", read2_data, ref_read(read2_enable, read2_addr));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Architectural general-purpose register file; terminal consumer of the write-back stream that the EX/MEM and MEM/WB buffers carry (write_enable, write_addr, write_data).
- Serves two decode-stage read ports with operand forwarding from the EX and MEM stage write-back signals.
- Sits between the writeback stage and the ID stage.

Parameters:
REG_COUNT, 32, number of architectural registers
ADDR_WIDTH, 5, register address width (log2 REG_COUNT)
DATA_WIDTH, 32, register data width

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
wb_write_enable  input  1  commit write from writeback stage
wb_write_addr  input  ADDR_WIDTH  commit destination register
wb_write_data  input  DATA_WIDTH  commit data
ex_write_enable  input  1  EX-stage result will write a register (forward source)
ex_write_addr  input  ADDR_WIDTH  EX-stage destination
ex_write_data  input  DATA_WIDTH  EX-stage result
mem_write_enable  input  1  MEM-stage result will write a register (forward source)
mem_write_addr  input  ADDR_WIDTH  MEM-stage destination
mem_write_data  input  DATA_WIDTH  MEM-stage result
read1_enable  input  1  port 1 read request
read1_addr  input  ADDR_WIDTH  port 1 source register
read1_data  output  DATA_WIDTH  port 1 operand
read2_enable  input  1  port 2 read request
read2_addr  input  ADDR_WIDTH  port 2 source register
read2_data  output  DATA_WIDTH  port 2 operand

Behaviour:
- Storage: REG_COUNT x DATA_WIDTH flip-flop array.
- Reset is asynchronous and active-high. While reset is high:
  - all entries clear to 0;
  - read1_data and read2_data drive 0 regardless of other inputs.
- Release of reset is synchronous to the next rising clock edge.
- Write:
  - On the rising edge with reset low and wb_write_enable high and wb_write_addr != 0, entry[wb_write_addr] <= wb_write_data.
  - Writes to address 0 are discarded. Entry 0 is constant 0.
- Reads are combinational, with zero cycle latency from address to data.
- Priority for each port n (first match wins):
  1. reset high -> 0
  2. readn_enable low -> 0
  3. readn_addr == 0 -> 0 (no forwarding to r0)
  4. ex_write_enable and ex_write_addr == readn_addr -> ex_write_data
  5. mem_write_enable and mem_write_addr == readn_addr -> mem_write_data
  6. wb_write_enable and wb_write_addr == readn_addr -> wb_write_data (same-cycle write-through bypass)
  7. otherwise -> entry[readn_addr]
- Both ports are fully independent. Both may read the same address, and each gets an identical result.
- Forward-source enables with address 0 never affect reads.
- EX/MEM forward inputs never modify storage. Only the wb_* port writes.
- Simultaneous EX, MEM and WB writes to the same address: the youngest (EX) value is returned and WB still commits. The next cycle returns the committed or forwarded value per the priority above.
- Reset asserted mid-cycle:
  - array clears immediately;
  - an in-flight write on the same edge is lost;
  - after release all registers read 0 until rewritten.
- Address decoding uses the full ADDR_WIDTH. Addresses >= REG_COUNT (if REG_COUNT < 2^ADDR_WIDTH) read 0 and ignore writes.

Test Plan:
- Reset then read: assert reset, read r1..r31 on both ports -> all 0; write r5=0xDEADBEEF with reset high -> after release r5 reads 0.
- Basic write/read: wb write r7=0x12345678 at edge N; at N+1 read1_addr=7, read1_enable=1 -> 0x12345678; same with read1_enable=0 -> 0.
- r0 protection: wb write r0=0xFFFFFFFF, ex_write_enable=1 ex_write_addr=0 ex_write_data=0xAAAA0000, read both ports addr 0 -> 0 on both.
- Write-through bypass: r3 holds 0x1; same cycle wb write r3=0x2 and read2_addr=3 -> read2_data=0x2 before the edge, 0x2 after.
- Forward priority: r9=0x10 in array; mem write r9=0x20, ex write r9=0x30, wb write r9=0x40 simultaneously -> read 0x30; drop ex -> 0x20; drop mem -> 0x40; next cycle no forwards -> 0x40 (committed).
- Async reset mid-operation: r12=0x55 stored, pulse reset between clock edges -> read1_data goes 0 immediately, r12 reads 0 after release.
